// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the TX frame arbiter: FSM state encoding,
// header length, counter widths and a saturating increment helper.
package tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_XFER       = 2'd2,
        ST_GAP        = 2'd3
    } arb_state_e;

    localparam int HDR_LEN     = 22;
    localparam int BYTE_CNT_W  = 16;
    localparam int START_CNT_W = 16;
    localparam int GAP_CNT_W   = 17;
    localparam int STAT_CNT_W  = 16;

    function automatic logic [STAT_CNT_W-1:0] sat_inc(input logic [STAT_CNT_W-1:0] v);
        if (v == {STAT_CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + STAT_CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_idx+1 with
// wrap and returns the first requester as one-hot plus index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    int               cand_s;
    logic [IDX_W-1:0] cand_idx_s;
    logic             found_s;

    // Walk the candidates in priority order and keep the first requester.
    always_comb begin
        gnt        = '0;
        idx        = '0;
        found_s    = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int i = 1; i <= N; i++) begin
            cand_s = int'(last_idx) + i;
            if (cand_s >= N) begin
                cand_s = cand_s - N;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = IDX_W'(cand_s);
            if (!found_s && req[cand_idx_s]) begin
                found_s         = 1'b1;
                gnt[cand_idx_s] = 1'b1;
                idx             = cand_idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter forwarding one source's byte burst per frame to the framer,
// with start timeout, payload truncation and inter-frame gap. Optional TX_ARB_STATS_EN adds statistics counters.
module tx_frame_arbiter
    import tx_arb_pkg::*;
#(
    parameter int                     NUM_SRC  = 4,
    parameter int                     MAX_LEN  = 1024,
    parameter int                     GUARD    = 8,
    parameter int                     START_TO = 255,
    parameter logic [NUM_SRC*8-1:0]   SRC_ID   = {8'h04, 8'h03, 8'h02, 8'h01}
) (
    input  logic                   i_clk163m84,
    input  logic                   i_rst,
    input  logic [NUM_SRC-1:0]     i_req,
    output logic [NUM_SRC-1:0]     o_grant,
    input  logic [NUM_SRC*8-1:0]   i_data,
    input  logic [NUM_SRC-1:0]     i_valid,
    output logic [7:0]             o_data_out,
    output logic                   o_data_valid,
    output logic [7:0]             o_info_unit_idenf,
    output logic                   o_busy,
    output logic                   o_err_overlen,
    output logic                   o_err_timeout
`ifdef TX_ARB_STATS_EN
    ,
    output logic [NUM_SRC*16-1:0]  o_frame_cnt,
    output logic [15:0]            o_err_cnt
`endif
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    if (MAX_LEN + HDR_LEN + GUARD >= (1 << GAP_CNT_W)) begin : g_gap_range_chk
        $error("tx_frame_arbiter: MAX_LEN+HDR_LEN+GUARD does not fit the gap counter");
    end

    arb_state_e              state_r, state_s;
    logic [NUM_SRC-1:0]      grant_r, grant_s;
    logic [IDX_W-1:0]        win_r, win_s;
    logic [7:0]              idenf_r, idenf_s;
    logic [7:0]              data_r, data_s;
    logic                    dv_r, dv_s;
    logic                    ovl_r, ovl_s;
    logic                    tmo_r, tmo_s;
    logic                    busy_r, busy_s;
    logic [BYTE_CNT_W-1:0]   byte_cnt_r, byte_cnt_s;
    logic [START_CNT_W-1:0]  start_cnt_r, start_cnt_s;
    logic [GAP_CNT_W-1:0]    gap_r, gap_s;

    logic [NUM_SRC-1:0]      arb_gnt_s;
    logic [IDX_W-1:0]        arb_idx_s;
    logic                    cur_valid_s;
    logic [7:0]              cur_data_s;

    // win_r doubles as the round-robin pointer: the search starts just above it.
    rr_arbiter #(
        .N     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_rr (
        .req      (i_req),
        .last_idx (win_r),
        .gnt      (arb_gnt_s),
        .idx      (arb_idx_s)
    );

    assign cur_valid_s = i_valid[win_r];
    assign cur_data_s  = i_data[{win_r, 3'b000} +: 8];

    // Next-state and next-output decode for the frame FSM.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        win_s       = win_r;
        idenf_s     = idenf_r;
        data_s      = 8'h00;
        dv_s        = 1'b0;
        ovl_s       = 1'b0;
        tmo_s       = 1'b0;
        byte_cnt_s  = byte_cnt_r;
        start_cnt_s = start_cnt_r;
        gap_s       = gap_r;
        case (state_r)
            ST_IDLE: begin
                if (|i_req) begin
                    state_s     = ST_WAIT_START;
                    grant_s     = arb_gnt_s;
                    win_s       = arb_idx_s;
                    idenf_s     = SRC_ID[{arb_idx_s, 3'b000} +: 8];
                    start_cnt_s = '0;
                    byte_cnt_s  = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_START: begin
                if (cur_valid_s) begin
                    state_s    = ST_XFER;
                    dv_s       = 1'b1;
                    data_s     = cur_data_s;
                    byte_cnt_s = BYTE_CNT_W'(1);
                end else if (start_cnt_r == START_CNT_W'(START_TO - 1)) begin
                    state_s = ST_IDLE;
                    tmo_s   = 1'b1;
                    grant_s = '0;
                end else begin
                    start_cnt_s = start_cnt_r + START_CNT_W'(1);
                end
            end
            ST_XFER: begin
                if (!cur_valid_s) begin
                    state_s = ST_GAP;
                    grant_s = '0;
                    gap_s   = GAP_CNT_W'(byte_cnt_r) + GAP_CNT_W'(HDR_LEN + GUARD);
                end else if (byte_cnt_r == BYTE_CNT_W'(MAX_LEN)) begin
                    // Truncate: the rest of this burst is dropped while the gap runs.
                    state_s = ST_GAP;
                    grant_s = '0;
                    ovl_s   = 1'b1;
                    gap_s   = GAP_CNT_W'(MAX_LEN + HDR_LEN + GUARD);
                end else begin
                    dv_s       = 1'b1;
                    data_s     = cur_data_s;
                    byte_cnt_s = byte_cnt_r + BYTE_CNT_W'(1);
                end
            end
            ST_GAP: begin
                // The loaded value is the number of cycles spent in GAP.
                if (gap_r <= GAP_CNT_W'(1)) begin
                    state_s = ST_IDLE;
                    gap_s   = '0;
                end else begin
                    gap_s = gap_r - GAP_CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = '0;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk163m84) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            grant_r     <= '0;
            win_r       <= IDX_W'(NUM_SRC - 1);
            idenf_r     <= 8'h00;
            data_r      <= 8'h00;
            dv_r        <= 1'b0;
            ovl_r       <= 1'b0;
            tmo_r       <= 1'b0;
            busy_r      <= 1'b0;
            byte_cnt_r  <= '0;
            start_cnt_r <= '0;
            gap_r       <= '0;
        end else begin
            state_r     <= state_s;
            grant_r     <= grant_s;
            win_r       <= win_s;
            idenf_r     <= idenf_s;
            data_r      <= data_s;
            dv_r        <= dv_s;
            ovl_r       <= ovl_s;
            tmo_r       <= tmo_s;
            busy_r      <= busy_s;
            byte_cnt_r  <= byte_cnt_s;
            start_cnt_r <= start_cnt_s;
            gap_r       <= gap_s;
        end
    end

    assign o_grant           = grant_r;
    assign o_data_out        = data_r;
    assign o_data_valid      = dv_r;
    assign o_info_unit_idenf = idenf_r;
    assign o_busy            = busy_r;
    assign o_err_overlen     = ovl_r;
    assign o_err_timeout     = tmo_r;

`ifdef TX_ARB_STATS_EN
    logic                   frame_done_s;
    logic                   err_evt_s;
    logic [NUM_SRC*16-1:0]  frame_cnt_r;
    logic [15:0]            err_cnt_r;

    // A frame completes when XFER hands over to GAP, truncated or not.
    always_comb begin
        frame_done_s = (state_r == ST_XFER) && (state_s == ST_GAP);
        err_evt_s    = ovl_s | tmo_s;
    end

    // Saturating per-source frame counters and shared error counter.
    always_ff @(posedge i_clk163m84) begin
        if (i_rst) begin
            frame_cnt_r <= '0;
            err_cnt_r   <= 16'h0000;
        end else begin
            if (frame_done_s) begin
                frame_cnt_r[{win_r, 4'b0000} +: 16] <= sat_inc(frame_cnt_r[{win_r, 4'b0000} +: 16]);
            end
            if (err_evt_s) begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end
        end
    end

    assign o_frame_cnt = frame_cnt_r;
    assign o_err_cnt   = err_cnt_r;
`endif

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Self-checking bench for tx_frame_arbiter: directed frame table, timeout,
// mid-frame reset, optional statistics, then randomized frames vs a round-robin model.
module tb_tx_frame_arbiter;

    localparam int NUM_SRC  = 4;
    localparam int MAX_LEN  = 1024;
    localparam int GUARD    = 8;
    localparam int START_TO = 255;
    localparam int HDR      = 22;

    logic        i_clk163m84 = 1'b0;
    logic        i_rst       = 1'b1;
    logic [3:0]  i_req       = 4'h0;
    logic [3:0]  o_grant;
    logic [31:0] i_data      = 32'h0;
    logic [3:0]  i_valid     = 4'h0;
    logic [7:0]  o_data_out;
    logic        o_data_valid;
    logic [7:0]  o_info_unit_idenf;
    logic        o_busy;
    logic        o_err_overlen;
    logic        o_err_timeout;
`ifdef TX_ARB_STATS_EN
    logic [63:0] o_frame_cnt;
    logic [15:0] o_err_cnt;
`endif

    tx_frame_arbiter dut (
        .i_clk163m84       (i_clk163m84),
        .i_rst             (i_rst),
        .i_req             (i_req),
        .o_grant           (o_grant),
        .i_data            (i_data),
        .i_valid           (i_valid),
        .o_data_out        (o_data_out),
        .o_data_valid      (o_data_valid),
        .o_info_unit_idenf (o_info_unit_idenf),
        .o_busy            (o_busy),
        .o_err_overlen     (o_err_overlen),
        .o_err_timeout     (o_err_timeout)
`ifdef TX_ARB_STATS_EN
        ,
        .o_frame_cnt       (o_frame_cnt),
        .o_err_cnt         (o_err_cnt)
`endif
    );

    always #5 i_clk163m84 = ~i_clk163m84;

    int          n_checks = 0;
    int          n_errors = 0;
    int          last_w   = NUM_SRC - 1;
    logic [31:0] src_ids  = 32'h04030201;

    typedef struct {
        logic [3:0] req;
        int         len;
        int         dly;
        int         exp_w;
        int         exp_gap;
        int         exp_fwd;
    } frame_vec_t;

    frame_vec_t vecs[9];

    task automatic step();
        @(posedge i_clk163m84);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference round-robin: first requester above the last winner, with wrap.
    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int i = 1; i <= NUM_SRC; i++) begin
            int c;
            c = (last + i) % NUM_SRC;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    // Drive source w; other sources get random valid/data noise.
    task automatic drive(input int w, input logic v, input logic [7:0] b);
        i_data          = $urandom;
        i_valid         = 4'($urandom);
        i_valid[w]      = v;
        i_data[w*8 +: 8] = b;
    endtask

    task automatic wait_grant(input int exp_w);
        int guard;
        guard = 0;
        while (o_grant == 4'h0 && guard < 300) begin
            step();
            guard++;
        end
        chk("grant", 32'(o_grant), 32'(4'b0001 << exp_w));
        chk("idenf", 32'(o_info_unit_idenf), 32'(src_ids[exp_w*8 +: 8]));
        chk("busy_grant", 32'(o_busy), 32'd1);
        last_w = exp_w;
    endtask

    task automatic run_frame(input int exp_w, input int len, input int dly, input int exp_gap, input int exp_fwd);
        int         gap_cnt;
        int         fwd_cnt;
        int         guard;
        bit         ended;
        logic [7:0] b;
        logic [3:0] oh;
        oh = 4'b0001 << exp_w;
        wait_grant(exp_w);
        i_req[exp_w] = 1'b0;
        for (int d = 0; d < dly; d++) begin
            drive(exp_w, 1'b0, 8'h00);
            step();
            chk("wait_grant_held", 32'(o_grant), 32'(oh));
            chk("wait_dv", 32'(o_data_valid), 32'd0);
        end
        ended   = 1'b0;
        gap_cnt = 0;
        fwd_cnt = 0;
        for (int j = 0; j <= len; j++) begin
            b = 8'($urandom);
            if (j < len) drive(exp_w, 1'b1, b);
            else drive(exp_w, 1'b0, 8'h00);
            step();
            if (o_data_valid) fwd_cnt++;
            if (!ended) begin
                if (j < len && j < MAX_LEN) begin
                    chk("fwd_valid", 32'(o_data_valid), 32'd1);
                    chk("fwd_data", 32'(o_data_out), 32'(b));
                end else begin
                    ended = 1'b1;
                    chk("end_dv", 32'(o_data_valid), 32'd0);
                    chk("end_grant", 32'(o_grant), 32'd0);
                    chk("end_overlen", 32'(o_err_overlen), 32'(j < len));
                    chk("end_busy", 32'(o_busy), 32'd1);
                end
            end else begin
                chk("drop_quiet", 32'({o_data_valid, o_err_overlen}), 32'd0);
            end
            if (ended && o_busy) gap_cnt++;
        end
        guard = 0;
        while (o_busy && guard < 3000) begin
            step();
            guard++;
            if (o_busy) gap_cnt++;
        end
        chk("gap_len", 32'(gap_cnt), 32'(exp_gap));
        chk("fwd_count", 32'(fwd_cnt), 32'(exp_fwd));
        chk("idle_grant", 32'(o_grant), 32'd0);
    endtask

    task automatic run_timeout(input int exp_w, input logic [3:0] after_req);
        logic [3:0] oh;
        oh = 4'b0001 << exp_w;
        wait_grant(exp_w);
        i_req = after_req;
        for (int k = 0; k < START_TO - 1; k++) begin
            drive(exp_w, 1'b0, 8'h00);
            step();
            chk("to_early", 32'({o_err_timeout, o_grant}), 32'({1'b0, oh}));
        end
        drive(exp_w, 1'b0, 8'h00);
        step();
        chk("to_pulse", 32'(o_err_timeout), 32'd1);
        chk("to_grant", 32'(o_grant), 32'd0);
        chk("to_busy", 32'(o_busy), 32'd0);
        step();
        chk("to_once", 32'(o_err_timeout), 32'd0);
    endtask

    initial begin
        int w;
        int len;

        vecs[0] = '{4'b1111, 10,   2, 0, 40,   10};
        vecs[1] = '{4'b1110, 3,    0, 1, 33,   3};
        vecs[2] = '{4'b1100, 1,    1, 2, 31,   1};
        vecs[3] = '{4'b1000, 7,    3, 3, 37,   7};
        vecs[4] = '{4'b0010, 10,   0, 1, 40,   10};
        vecs[5] = '{4'b0100, 1030, 1, 2, 1054, 1024};
        vecs[6] = '{4'b1001, 5,    0, 3, 35,   5};
        vecs[7] = '{4'b1010, 2,    4, 1, 32,   2};
        vecs[8] = '{4'b1000, 4,    0, 3, 34,   4};

        i_rst = 1'b1;
        for (int k = 0; k < 3; k++) step();
        chk("reset_outputs", 32'({o_grant, o_data_out, o_data_valid, o_info_unit_idenf,
                                  o_busy, o_err_overlen, o_err_timeout}), 32'd0);
        i_rst = 1'b0;

        for (int r = 0; r < 9; r++) begin
            i_req = vecs[r].req;
            run_frame(vecs[r].exp_w, vecs[r].len, vecs[r].dly, vecs[r].exp_gap, vecs[r].exp_fwd);
        end

        // Source 0 never starts; source 1 is waiting behind it.
        i_req = 4'b0011;
        run_timeout(0, 4'b0010);
        run_frame(1, 3, 0, 33, 3);

        // Reset lands together with the fifth byte of a frame.
        i_req = 4'b0100;
        wait_grant(2);
        i_req = 4'b0000;
        for (int j = 0; j < 5; j++) begin
            drive(2, 1'b1, 8'(8'h10 + j));
            if (j == 4) i_rst = 1'b1;
            step();
            if (j < 4) chk("pre_rst_dv", 32'(o_data_valid), 32'd1);
        end
        chk("mid_rst_outputs", 32'({o_grant, o_data_out, o_data_valid, o_info_unit_idenf,
                                    o_busy, o_err_overlen, o_err_timeout}), 32'd0);
        i_rst   = 1'b0;
        i_valid = 4'h0;
        last_w  = NUM_SRC - 1;
        i_req   = 4'b1111;
        run_frame(0, 6, 1, 36, 6);

`ifdef TX_ARB_STATS_EN
        for (int f = 0; f < 3; f++) begin
            i_req = 4'b1000;
            run_frame(3, 4, 0, 34, 4);
        end
        i_req = 4'b1000;
        run_timeout(3, 4'b0000);
        chk("stat_frames_src3", 32'(o_frame_cnt[63:48]), 32'd3);
        chk("stat_err_cnt", 32'(o_err_cnt), 32'd1);
`endif

        i_req = 4'b0000;
        for (int it = 0; it < 40; it++) begin
            i_req = 4'($urandom_range(1, 15));
            w     = rr_pick(i_req, last_w);
            if ($urandom_range(0, 7) == 0) begin
                run_timeout(w, 4'b0000);
            end else begin
                len = $urandom_range(1, 40);
                run_frame(w, len, $urandom_range(0, 6), len + HDR + GUARD, len);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
